// File: rtl/alu_response_checker.sv
// rtl/alu_response_checker.sv - two-stage ALU response checker with saturating counters and opcode coverage; `define FAIL_CAPTURE_EN adds first-failure capture
module alu_response_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [3:0]       sel,
    input  logic [7:0]       out,
    input  logic             carry,
    output logic             res_valid,
    output logic             res_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [15:0]      cov_mask,
    output logic             cov_done
`ifdef FAIL_CAPTURE_EN
    ,
    output logic [7:0]       fail_a,
    output logic [7:0]       fail_b,
    output logic [7:0]       fail_out,
    output logic [3:0]       fail_sel
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    typedef enum logic {
        RUN  = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     state;
    logic       run_q;
    logic       accept;
    logic       s1_valid;
    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic [3:0] s1_sel;
    logic [7:0] s1_out;
    logic       s1_carry;
    logic [8:0] sum9;
    logic [7:0] exp_out;
    logic       check_pass;
    logic       near_full;

    // in_ready is held low for the whole time rst_n is asserted
    assign in_ready = run_q & rst_n;
    assign accept   = in_valid & in_ready;
    assign cov_done = &cov_mask;

    always_comb begin
        sum9    = {1'b0, s1_a} + {1'b0, s1_b};
        exp_out = 8'h00;
        case (s1_sel)
            4'd0:  exp_out = sum9[7:0];
            4'd1:  exp_out = s1_a - s1_b;
            4'd2:  exp_out = s1_a * s1_b;
            4'd3:  exp_out = (s1_b == 8'h00) ? 8'hFF : s1_a / s1_b;
            4'd4:  exp_out = {s1_a[6:0], 1'b0};
            4'd5:  exp_out = {1'b0, s1_a[7:1]};
            4'd6:  exp_out = {s1_a[6:0], s1_a[7]};
            4'd7:  exp_out = {s1_a[0], s1_a[7:1]};
            4'd8:  exp_out = s1_a & s1_b;
            4'd9:  exp_out = s1_a | s1_b;
            4'd10: exp_out = s1_a ^ s1_b;
            4'd11: exp_out = ~(s1_a | s1_b);
            4'd12: exp_out = ~(s1_a & s1_b);
            4'd13: exp_out = ~(s1_a ^ s1_b);
            4'd14: exp_out = {7'd0, s1_a > s1_b};
            4'd15: exp_out = {7'd0, s1_a == s1_b};
            default: exp_out = 8'h00;
        endcase
    end

    // carry is always the adder carry, whatever the opcode
    assign check_pass = (s1_out == exp_out) && (s1_carry == sum9[8]);
    assign near_full  = check_pass ? (pass_cnt == CNT_NEAR) : (fail_cnt == CNT_NEAR);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= RUN;
            run_q     <= 1'b1;
            s1_valid  <= 1'b0;
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err       <= 1'b0;
            cov_mask  <= 16'h0000;
`ifdef FAIL_CAPTURE_EN
            fail_a    <= 8'h00;
            fail_b    <= 8'h00;
            fail_out  <= 8'h00;
            fail_sel  <= 4'h0;
`endif
        end else begin
            s1_valid  <= accept;
            res_valid <= s1_valid;
            res_pass  <= s1_valid && check_pass;
            if (accept) begin
                s1_a     <= a;
                s1_b     <= b;
                s1_sel   <= sel;
                s1_out   <= out;
                s1_carry <= carry;
            end
            if (s1_valid) begin
                cov_mask[s1_sel] <= 1'b1;
                if (check_pass) begin
                    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
                end else begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                    err <= 1'b1;
`ifdef FAIL_CAPTURE_EN
                    if (!err) begin
                        fail_a   <= s1_a;
                        fail_b   <= s1_b;
                        fail_out <= s1_out;
                        fail_sel <= s1_sel;
                    end
`endif
                end
                // stop accepting once a counter is about to saturate; in-flight checks still drain
                if (state == RUN && near_full) begin
                    state <= FULL;
                    run_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/alu_response_checker.md
ALU_RESPONSE_CHECKER -- requirements
Module: alu_response_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the pass and fail counters.
REQ-002 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port clr, input, 1 bit: synchronous clear of counters, coverage and error state.
REQ-005 Port in_valid, input, 1 bit: the transaction on a/b/sel/out/carry is valid.
REQ-006 Port in_ready, output, 1 bit: the checker accepts a transaction this cycle.
REQ-007 Ports a and b, input, 8 bits each: the ALU operands as driven to the ALU.
REQ-008 Port sel, input, 4 bits: the ALU opcode.
REQ-009 Port out, input, 8 bits: the ALU result under check.
REQ-010 Port carry, input, 1 bit: the ALU carry under check.
REQ-011 Port res_valid, output, 1 bit: one-cycle pulse when a check completes.
REQ-012 Port res_pass, output, 1 bit: the result of the check; meaningful only while res_valid is high.
REQ-013 Ports pass_cnt and fail_cnt, output, CNT_W bits each: saturating totals of passing and failing checks.
REQ-014 Port err, output, 1 bit: sticky flag, set by any failure.
REQ-015 Port cov_mask, output, 16 bits: bit k is set once opcode k has been checked.
REQ-016 Port cov_done, output, 1 bit: high when cov_mask is all ones.
REQ-017 Ports fail_a, fail_b, fail_out, output, 8 bits each, and fail_sel, output, 4 bits: the first failing transaction; present only under FAIL_CAPTURE_EN.

Function
REQ-018 A transaction SHALL be accepted in a cycle where in_valid and in_ready are both high.
- Stage 1 registers a, b, sel, out and carry in the acceptance cycle.
- Stage 2 compares in the next cycle.
- res_valid is asserted exactly 2 cycles after acceptance.
- The counters, err and cov_mask update in the same cycle as res_valid.
REQ-019 The pipeline SHALL sustain one transaction per cycle with no bubbles while in_ready is high.
REQ-020 The expected result SHALL be computed as follows, keeping the low 8 bits:
- Opcodes 0 to 3: add, subtract, multiply, divide; divide by b=0 gives 8'hFF.
- Opcodes 4 to 7: shift left by 1, shift right by 1, rotate left by 1, rotate right by 1.
- Opcodes 8 to 13: and, or, xor, nor, nand, xnor.
- Opcode 14: 8'h01 if a>b unsigned, else 8'h00.
- Opcode 15: 8'h01 if a==b, else 8'h00.
REQ-021 The expected carry SHALL be bit 8 of the 9-bit sum {1'b0,a}+{1'b0,b} for every opcode.
REQ-022 res_pass SHALL be 1 only when out and carry both match the expected values.
REQ-023 The state machine SHALL have two states, RUN and FULL.
- RUN drives in_ready=1.
- RUN goes to FULL when a counter update would reach the value all-ones.
- FULL drives in_ready=0 and lets the transactions already in the pipeline drain; saturated counters hold.
- FULL goes to RUN only on clr or reset.
REQ-024 clr SHALL zero the counters, err, cov_mask and the capture registers, return the machine to RUN, and flush both pipeline stages so no res_valid is produced for flushed transactions.
REQ-025 If clr and a completing check occur in the same cycle, clr SHALL win and the check result SHALL be discarded.
REQ-026 While in_valid is low, no state SHALL change except draining of the pipeline.
REQ-027 The inputs a, b, sel, out and carry SHALL be ignored when the transaction is not accepted.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL apply the following:
- in_ready=0 during reset, and 1 in the first cycle after release.
- res_valid=0, res_pass=0, pass_cnt=0, fail_cnt=0, err=0.
- cov_mask=0, cov_done=0, and the fail_* outputs all 0.
- Both pipeline stages are emptied and the state is RUN.
REQ-029 A reset that arrives mid-transaction SHALL discard all in-flight checks with no res_valid afterwards.

Configuration
REQ-030 The macro FAIL_CAPTURE_EN SHALL control first-failure capture.
- When defined: the fail_* ports exist and load on the first failing check after reset or clr, then hold until reset or clr.
- When undefined: the fail_* ports and their registers are absent.
- All other behaviour is identical in both cases.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Sweep: a=8'h0A, b=8'h02, sel 0..15, ALU results correct -> 16 passes, pass_cnt=16, fail_cnt=0, cov_done=1, err=0.
- Wrong result: a=8'hF6, b=8'h0A, sel=0, out=8'h00, carry=1 -> pass (sum is 9'h100); the same with out=8'h01 -> res_pass=0, err=1, fail_out=8'h01 (with FAIL_CAPTURE_EN).
- Divide by zero: sel=3, a=8'h10, b=0, out=8'hFF, carry=0 -> pass.
- Saturation: CNT_W=4, 15 passes -> in_ready=0, pass_cnt=4'hF; then clr -> counters 0, in_ready=1.
- Clear and reset: clr in the res_valid cycle of a failure -> fail_cnt stays 0; rst_n low one cycle after acceptance -> no res_valid.
